// File: rtl/operand_gather_ctrl.sv
// Shares one 3-slot operand gather buffer among NUM_REQ requesters using round-robin ownership.
// Optional idle-owner timeout: define GATHER_TIMEOUT_EN to flush a partial bundle after TIMEOUT_CYC idle cycles.
module operand_gather_ctrl #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16,
    localparam int OW         = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_op0,
    output logic [DATA_W-1:0]         out_op1,
    output logic [DATA_W-1:0]         out_op2,
    output logic [1:0]                out_count,
    output logic [OW-1:0]             out_owner,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2
    } state_e;

    state_e              state_q;
    logic [OW-1:0]       owner_q;
    logic [OW-1:0]       rr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic [DATA_W-1:0]   slot0_q;
    logic [DATA_W-1:0]   slot1_q;
    logic [DATA_W-1:0]   slot2_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [OW-1:0]       pick_hi_s;
    logic [OW-1:0]       pick_lo_s;
    logic                found_hi_s;
    logic                found_lo_s;
    logic [OW-1:0]       pick_s;
    logic [OW-1:0]       rr_next_s;
    logic                cur_req_s;
    logic                cur_last_s;
    logic [DATA_W-1:0]   cur_data_s;

`ifdef GATHER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]       idle_cnt_q;
`endif

    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [OW-1:0] idx);
        onehot_f = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Cyclic search: lowest requester at/after rr_q wins, else lowest overall
    always_comb begin
        pick_hi_s  = '0;
        pick_lo_s  = '0;
        found_hi_s = 1'b0;
        found_lo_s = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_lo_s  = OW'(i);
                found_lo_s = 1'b1;
                if (OW'(i) >= rr_q) begin
                    pick_hi_s  = OW'(i);
                    found_hi_s = 1'b1;
                end else begin
                    found_hi_s = found_hi_s;
                end
            end else begin
                found_lo_s = found_lo_s;
            end
        end
        pick_s = found_hi_s ? pick_hi_s : pick_lo_s;
    end

    // Select the owner's request lane and derive next pointer/count
    always_comb begin
        cur_req_s  = 1'b0;
        cur_last_s = 1'b0;
        cur_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_req_s  = (owner_q == OW'(i)) ? req[i] : cur_req_s;
            cur_last_s = (owner_q == OW'(i)) ? req_last[i] : cur_last_s;
            cur_data_s = (owner_q == OW'(i)) ? req_data[i*DATA_W +: DATA_W] : cur_data_s;
        end
        rr_next_s = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
        count_d   = count_q + 2'd1;
    end

    // Ownership FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            count_q     <= 2'd0;
            slot0_q     <= '0;
            slot1_q     <= '0;
            slot2_q     <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GATHER_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_lo_s) begin
                        owner_q <= pick_s;
                        gnt_q   <= onehot_f(pick_s);
                        busy_q  <= 1'b1;
                        state_q <= ST_COLLECT;
`ifdef GATHER_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (cur_req_s) begin
                        case (count_q)
                            2'd0:    slot0_q <= cur_data_s;
                            2'd1:    slot1_q <= cur_data_s;
                            default: slot2_q <= cur_data_s;
                        endcase
                        count_q <= count_d;
`ifdef GATHER_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                        if (cur_last_s || (count_d == 2'd3)) begin
                            state_q     <= ST_ISSUE;
                            gnt_q       <= '0;
                            out_valid_q <= 1'b1;
                        end
                    end
`ifdef GATHER_TIMEOUT_EN
                    else if (count_q != 2'd0) begin
                        // Owner went quiet with a partial bundle: flush it after the limit
                        if (idle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                            state_q     <= ST_ISSUE;
                            gnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            idle_cnt_q  <= '0;
                        end else begin
                            idle_cnt_q  <= idle_cnt_q + TW'(1);
                        end
                    end
`endif
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        slot0_q     <= '0;
                        slot1_q     <= '0;
                        slot2_q     <= '0;
                        count_q     <= 2'd0;
                        rr_q        <= rr_next_s;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_op0   = slot0_q;
    assign out_op1   = slot1_q;
    assign out_op2   = slot2_q;
    assign out_count = count_q;
    assign out_owner = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_operand_gather_ctrl.sv
// Directed self-checking bench for operand_gather_ctrl (NUM_REQ=2, DATA_W=8).
module tb_operand_gather_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  op0, op1, op2;
    logic [1:0]  out_count;
    logic [0:0]  out_owner;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    operand_gather_ctrl #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_op0(op0), .out_op1(op1), .out_op2(op2),
        .out_count(out_count), .out_owner(out_owner), .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] l);
        req      = r;
        req_data = {d1, d0};
        req_last = l;
    endtask

    task automatic test_reset;
        reset = 1'b1; out_ready = 1'b0;
        drive(2'b11, 8'h5A, 8'hA5, 2'b00);
        step; step;
        n_cmp++; if ({out_valid, busy, gnt, out_count, out_owner} !== 7'd0) begin n_bad++; $display("FAIL reset_ctrl got=%h want=0", {out_valid, busy, gnt, out_count, out_owner}); end
        n_cmp++; if ({op0, op1, op2} !== 24'd0) begin n_bad++; $display("FAIL reset_ops got=%h want=0", {op0, op1, op2}); end
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        reset = 1'b0;
    endtask

    task automatic test_full_bundle;
        drive(2'b01, 8'h11, 8'h00, 2'b00);
        step;
        n_cmp++; if ({gnt, busy, out_valid} !== {2'b01, 1'b1, 1'b0}) begin n_bad++; $display("FAIL full_arb got=%b want=0110", {gnt, busy, out_valid}); end
        step;
        drive(2'b01, 8'h22, 8'h00, 2'b00);
        step;
        drive(2'b01, 8'h33, 8'h00, 2'b01);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid got=%b want=0", out_valid); end
        step;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        n_cmp++; if ({out_valid, gnt} !== 3'b100) begin n_bad++; $display("FAIL full_valid got=%b want=100", {out_valid, gnt}); end
        n_cmp++; if ({op0, op1, op2} !== 24'h112233) begin n_bad++; $display("FAIL full_ops got=%h want=112233", {op0, op1, op2}); end
        n_cmp++; if ({out_count, out_owner} !== {2'd3, 1'b0}) begin n_bad++; $display("FAIL full_cnt_owner got=%b want=110", {out_count, out_owner}); end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        n_cmp++; if ({out_valid, busy, out_count} !== 4'd0) begin n_bad++; $display("FAIL full_release got=%b want=0000", {out_valid, busy, out_count}); end
    endtask

    task automatic test_stall;
        drive(2'b10, 8'h00, 8'hA5, 2'b10);
        step;
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL stall_rr_gnt got=%b want=10", gnt); end
        step;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out_valid, op0, op1, op2, out_count, out_owner} !== {1'b1, 24'hA50000, 2'd1, 1'b1}) begin
                n_bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, {out_valid, op0, op1, op2, out_count, out_owner}, {1'b1, 24'hA50000, 2'd1, 1'b1});
            end
            step;
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL stall_release got=%b want=00", {out_valid, busy}); end
    endtask

    task automatic test_back_to_back;
        int ptr0 = 0;
        int ptr1 = 0;
        int b = 0;
        int base;
        logic [1:0] g;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && b < 4; cyc++) begin
            req      = {(ptr1 < 6), (ptr0 < 6)};
            req_data = {8'(ptr1 + 1), 8'(ptr0 + 1)};
            req_last = 2'b00;
            g = gnt;
            step;
            if (req[0] && g[0]) ptr0++;
            if (req[1] && g[1]) ptr1++;
            if (out_valid) begin
                base = (b / 2) * 3;
                n_cmp++; if ({out_owner, out_count} !== {1'(b % 2), 2'd3}) begin n_bad++; $display("FAIL b2b_owner bundle=%0d got=%b want=%b", b, {out_owner, out_count}, {1'(b % 2), 2'd3}); end
                n_cmp++; if ({op0, op1, op2} !== {8'(base + 1), 8'(base + 2), 8'(base + 3)}) begin n_bad++; $display("FAIL b2b_ops bundle=%0d got=%h want=%h", b, {op0, op1, op2}, {8'(base + 1), 8'(base + 2), 8'(base + 3)}); end
                b++;
            end
        end
        n_cmp++; if (b !== 4) begin n_bad++; $display("FAIL b2b_bundles got=%0d want=4", b); end
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        step;
        out_ready = 1'b0;
    endtask

    task automatic test_owner_hold;
        drive(2'b01, 8'h10, 8'h00, 2'b00);
        step; step;
        drive(2'b10, 8'h00, 8'h99, 2'b00);
`ifdef GATHER_TIMEOUT_EN
        begin
            logic to_seen = 1'b0;
            for (int cyc = 0; cyc < 20 && !to_seen; cyc++) begin
                n_cmp++; if (gnt[1] !== 1'b0) begin n_bad++; $display("FAIL hold_gnt1 cyc=%0d got=%b want=0", cyc, gnt[1]); end
                step;
                if (out_valid) to_seen = 1'b1;
            end
            n_cmp++; if (to_seen !== 1'b1) begin n_bad++; $display("FAIL hold_timeout got=%b want=1", to_seen); end
            n_cmp++; if ({op0, op1, op2, out_count, out_owner} !== {24'h100000, 2'd1, 1'b0}) begin n_bad++; $display("FAIL hold_partial got=%h want=%h", {op0, op1, op2, out_count, out_owner}, {24'h100000, 2'd1, 1'b0}); end
            out_ready = 1'b1;
            step;
            out_ready = 1'b0;
            step;
            n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL hold_next_owner got=%b want=10", gnt); end
        end
`else
        for (int cyc = 0; cyc < 20; cyc++) begin
            step;
            n_cmp++; if ({gnt, out_valid} !== 3'b010) begin n_bad++; $display("FAIL hold_keep cyc=%0d got=%b want=010", cyc, {gnt, out_valid}); end
        end
        drive(2'b01, 8'h20, 8'h00, 2'b01);
        step;
        n_cmp++; if ({out_valid, op0, op1, op2, out_count, out_owner} !== {1'b1, 24'h102000, 2'd2, 1'b0}) begin n_bad++; $display("FAIL hold_resume got=%h want=%h", {out_valid, op0, op1, op2, out_count, out_owner}, {1'b1, 24'h102000, 2'd2, 1'b0}); end
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
`endif
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        step;
        reset = 1'b0;
        drive(2'b01, 8'hE1, 8'h00, 2'b01);
        step; step;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        drive(2'b10, 8'h00, 8'h55, 2'b00);
        step; step;
        drive(2'b10, 8'h00, 8'h66, 2'b00);
        step;
        reset = 1'b1;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        step;
        reset = 1'b0;
        n_cmp++; if ({out_valid, busy, gnt, out_count, out_owner, op0, op1, op2} !== 31'd0) begin n_bad++; $display("FAIL midrst_clear got=%h want=0", {out_valid, busy, gnt, out_count, out_owner, op0, op1, op2}); end
        step;
        n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL midrst_quiet got=%b want=00", {out_valid, busy}); end
        drive(2'b11, 8'h77, 8'h88, 2'b11);
        step;
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL midrst_rr0 got=%b want=01", gnt); end
        step;
        n_cmp++; if ({out_valid, op0, op1, op2, out_count, out_owner} !== {1'b1, 24'h770000, 2'd1, 1'b0}) begin n_bad++; $display("FAIL midrst_b0 got=%h want=%h", {out_valid, op0, op1, op2, out_count, out_owner}, {1'b1, 24'h770000, 2'd1, 1'b0}); end
        drive(2'b10, 8'h00, 8'h88, 2'b10);
        out_ready = 1'b1;
        step; step;
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL midrst_gnt1 got=%b want=10", gnt); end
        step;
        n_cmp++; if ({out_valid, op0, op1, op2, out_count, out_owner} !== {1'b1, 24'h880000, 2'd1, 1'b1}) begin n_bad++; $display("FAIL midrst_b1 got=%h want=%h", {out_valid, op0, op1, op2, out_count, out_owner}, {1'b1, 24'h880000, 2'd1, 1'b1}); end
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        step;
        out_ready = 1'b0;
    endtask

    task automatic test_last_on_third;
        int pulses = 0;
        out_ready = 1'b1;
        drive(2'b01, 8'hC1, 8'h00, 2'b00);
        step; step;
        drive(2'b01, 8'hC2, 8'h00, 2'b00);
        step;
        drive(2'b01, 8'hC3, 8'h00, 2'b01);
        step;
        drive(2'b00, 8'h00, 8'h00, 2'b00);
        n_cmp++; if ({out_valid, op0, op1, op2, out_count} !== {1'b1, 24'hC1C2C3, 2'd3}) begin n_bad++; $display("FAIL last3_bundle got=%h want=%h", {out_valid, op0, op1, op2, out_count}, {1'b1, 24'hC1C2C3, 2'd3}); end
        pulses = 1;
        for (int i = 0; i < 6; i++) begin
            step;
            if (out_valid) pulses++;
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL last3_pulses got=%0d want=1", pulses); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL last3_idle got=%b want=0", busy); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_full_bundle;
        test_stall;
        test_back_to_back;
        test_owner_hold;
        test_reset_mid;
        test_last_on_third;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
